rv32i_writeback_unit: RTL and testbench

- Writer-side counterpart of the integer register file write port.
- Collects completed results from the ALU and load/store unit over valid/ready handshakes.
- Formats load data (byte/half/word, sign or zero extension) and arbitrates the two sources onto the single write port.
- Drives rd_we/rd_addr/rd_wdata from registered outputs, one write per cycle.

---
 rtl/rv32i_core_pkg.sv | 14 +
 rtl/rv32i_load_formatter.sv | 25 ++
 rtl/rv32i_writeback_unit.sv | 65 ++++++
 tb/tb_rv32i_writeback_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_core_pkg.sv
// rv32i_core_pkg: shared core types and constants for the writeback path
package rv32i_core_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned WB_MAX_WAIT_DEFAULT = 4;
    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;
    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] wdata;
    } wb_req_t;
endpackage

// File: rtl/rv32i_load_formatter.sv
// rv32i_load_formatter: selects the addressed byte/half of a load word and extends it
module rv32i_load_formatter
    import rv32i_core_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        byte_off,
    output logic [XLEN_P-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    // byte_off[0] is ignored for halves; misaligned halves never reach here
    assign b = raw[{byte_off, 3'b000} +: 8];
    assign h = raw[{byte_off[1], 4'b0000} +: 16];
    always_comb begin
        result = raw;
        if (size == LSU_B)
            result = {{(XLEN_P-8){b[7] & ~is_unsigned}}, b};
        else if (size == LSU_H)
            result = {{(XLEN_P-16){h[15] & ~is_unsigned}}, h};
    end
endmodule

// File: rtl/rv32i_writeback_unit.sv
// rv32i_writeback_unit: arbitrates ALU and load results onto the single register file write port
module rv32i_writeback_unit
    import rv32i_core_pkg::*;
#(
    parameter int unsigned XLEN_P     = XLEN,
    parameter int unsigned MAX_WAIT_P = WB_MAX_WAIT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [4:0]        alu_rd_addr_i,
    input  logic [XLEN_P-1:0] alu_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [4:0]        lsu_rd_addr_i,
    input  logic [XLEN_P-1:0] lsu_rdata_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_unsigned_i,
    input  logic [1:0]        lsu_byte_off_i,
    output logic              rd_we_o,
    output logic [4:0]        rd_addr_o,
    output logic [XLEN_P-1:0] rd_wdata_o
);
    logic [3:0]        wait_cnt;
    logic              alu_pri;
    logic              grant;
    logic              wr;
    logic [XLEN_P-1:0] ld_data;
    wb_req_t           req;

    rv32i_load_formatter #(.XLEN_P(XLEN_P)) u_fmt (
        .raw         (lsu_rdata_i),
        .size        (lsu_size_i),
        .is_unsigned (lsu_unsigned_i),
        .byte_off    (lsu_byte_off_i),
        .result      (ld_data)
    );

    // LSU wins contention until the ALU has been held MAX_WAIT_P cycles
    assign alu_pri     = wait_cnt >= 4'(MAX_WAIT_P);
    assign alu_ready_o = !rst_i && alu_valid_i && (!lsu_valid_i || alu_pri);
    assign lsu_ready_o = !rst_i && lsu_valid_i && !(alu_valid_i && alu_pri);
    assign grant       = alu_ready_o || lsu_ready_o;
    assign req         = alu_ready_o ? wb_req_t'{alu_rd_addr_i, alu_wdata_i}
                                     : wb_req_t'{lsu_rd_addr_i, ld_data};
    assign wr          = grant && (req.rd_addr != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_we_o    <= 1'b0;
            rd_addr_o  <= '0;
            rd_wdata_o <= '0;
            wait_cnt   <= '0;
        end else begin
            rd_we_o <= wr;
            if (wr) begin
                rd_addr_o  <= req.rd_addr;
                rd_wdata_o <= req.wdata;
            end
            wait_cnt <= (!alu_valid_i || alu_ready_o) ? 4'd0
                      : (lsu_ready_o && wait_cnt != 4'hF) ? wait_cnt + 4'd1 : wait_cnt;
        end
    end
endmodule

// File: tb/tb_rv32i_writeback_unit.sv
// tb_rv32i_writeback_unit: scoreboard bench for the writeback arbiter and load formatter
module tb_rv32i_writeback_unit;
    localparam int MAX_WAIT = 4;
    localparam logic [31:0] RAW = 32'h80F1_7F82;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_wdata_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_rdata_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [1:0]  lsu_byte_off_i;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_wdata_o;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_wait = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic        alu_granted;

    rv32i_writeback_unit #(.MAX_WAIT_P(MAX_WAIT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_addr_i  (alu_rd_addr_i),
        .alu_wdata_i    (alu_wdata_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .rd_we_o        (rd_we_o),
        .rd_addr_o      (rd_addr_o),
        .rd_wdata_o     (rd_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = v; alu_rd_addr_i = rd; alu_wdata_i = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d,
                           input logic [1:0] sz, input logic uns, input logic [1:0] off);
        lsu_valid_i = v; lsu_rd_addr_i = rd; lsu_rdata_i = d;
        lsu_size_i = sz; lsu_unsigned_i = uns; lsu_byte_off_i = off;
    endtask

    // One clock: predict readies, push the accepted result, then compare the write port
    task automatic tick(input logic [31:0] exp_ld);
        logic ea, el;
        exp_t e;
        @(negedge clk_i);
        ea = !rst_i && alu_valid_i && (!lsu_valid_i || m_wait >= MAX_WAIT);
        el = !rst_i && lsu_valid_i && !(alu_valid_i && m_wait >= MAX_WAIT);
        check("alu_ready", 32'(alu_ready_o), 32'(ea));
        check("lsu_ready", 32'(lsu_ready_o), 32'(el));
        alu_granted = ea;
        @(posedge clk_i);
        if (rst_i) begin
            q.delete();
            m_wait = 0;
            last_addr = '0;
            last_data = '0;
        end else begin
            if (ea) begin
                e = '{alu_rd_addr_i != 5'd0, alu_rd_addr_i, alu_wdata_i};
                q.push_back(e);
            end else if (el) begin
                e = '{lsu_rd_addr_i != 5'd0, lsu_rd_addr_i, exp_ld};
                q.push_back(e);
            end
            m_wait = (!alu_valid_i || ea) ? 0 : (el && m_wait < 15) ? m_wait + 1 : m_wait;
        end
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rd_we", 32'(rd_we_o), 32'(e.we));
            if (e.we) begin
                last_addr = e.addr;
                last_data = e.data;
            end
        end else begin
            check("rd_we_idle", 32'(rd_we_o), 32'd0);
        end
        check("rd_addr", 32'(rd_addr_o), 32'(last_addr));
        check("rd_wdata", rd_wdata_o, last_data);
    endtask

    initial begin
        rst_i = 1'b1;
        set_alu(1'b1, 5'd5, 32'h1111_1111);
        set_lsu(1'b1, 5'd5, RAW, 2'b10, 1'b0, 2'd0);
        repeat (3) tick(RAW);
        rst_i = 1'b0;
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        set_alu(1'b1, 5'd3, 32'hDEAD_BEEF);
        tick(32'h0);
        set_alu(1'b0, 5'd0, 32'h0);
        tick(32'h0);
        set_lsu(1'b1, 5'd9,  RAW, 2'b00, 1'b0, 2'd0); tick(32'hFFFF_FF82);
        set_lsu(1'b1, 5'd10, RAW, 2'b00, 1'b1, 2'd1); tick(32'h0000_007F);
        set_lsu(1'b1, 5'd11, RAW, 2'b01, 1'b0, 2'd2); tick(32'hFFFF_80F1);
        set_lsu(1'b1, 5'd12, RAW, 2'b10, 1'b0, 2'd0); tick(RAW);
        set_lsu(1'b1, 5'd13, RAW, 2'b11, 1'b0, 2'd3); tick(RAW);
        set_lsu(1'b1, 5'd14, RAW, 2'b01, 1'b1, 2'd1); tick(32'h0000_7F82);
        set_lsu(1'b1, 5'd15, RAW, 2'b00, 1'b0, 2'd3); tick(32'hFFFF_FF80);
        set_lsu(1'b1, 5'd16, RAW, 2'b00, 1'b0, 2'd2); tick(32'hFFFF_FFF1);
        set_lsu(1'b1, 5'd0, 32'h1234_5678, 2'b10, 1'b0, 2'd0); tick(32'h1234_5678);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        set_alu(1'b1, 5'd7, 32'h0000_0077); tick(32'h0);
        set_alu(1'b0, 5'd0, 32'h0); tick(32'h0);
        set_alu(1'b1, 5'd20, 32'hA000_0000);
        for (int i = 0; i < 10; i++) begin
            set_lsu(1'b1, 5'd21, 32'h0101_0101 * (i + 1), 2'b10, 1'b0, 2'd0);
            tick(32'h0101_0101 * (i + 1));
            check("alu_grant_seq", 32'(alu_granted), 32'((i % 5) == 4));
            if (alu_granted) alu_wdata_i = alu_wdata_i + 32'd1;
        end
        tick(32'h0101_0101 * 10);
        rst_i = 1'b1;
        tick(32'h0);
        rst_i = 1'b0;
        set_lsu(1'b1, 5'd22, 32'h5555_AAAA, 2'b10, 1'b0, 2'd0);
        tick(32'h5555_AAAA);
        set_alu(1'b0, 5'd0, 32'h0);
        tick(32'h5555_AAAA);
        set_alu(1'b1, 5'd23, 32'hC0DE_0001);
        repeat (5) tick(32'h5555_AAAA);
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 2'd0);
        tick(32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
